// File: rtl/bram1_arb_pkg.sv
// Shared types for the single-port BRAM arbiter: FSM state encoding and requester index.
package bram1_arb_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_t;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_idx_t;

  // One-hot grant for the requester currently holding priority.
  function automatic logic [1:0] prio_onehot(input req_idx_t prio);
    return (prio == REQ0) ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/bram1_port_arb_if.sv
// Two-requester handshake bus into the BRAM arbiter; master = requester side, slave = arbiter.
interface bram1_port_arb_if #(
  parameter int ABITS = 8,
  parameter int DBITS = 8
);

  logic             r0_valid;
  logic             r0_ready;
  logic             r0_we;
  logic [ABITS-1:0] r0_addr;
  logic [DBITS-1:0] r0_wdata;
  logic             r0_rvalid;
  logic [DBITS-1:0] r0_rdata;

  logic             r1_valid;
  logic             r1_ready;
  logic             r1_we;
  logic [ABITS-1:0] r1_addr;
  logic [DBITS-1:0] r1_wdata;
  logic             r1_rvalid;
  logic [DBITS-1:0] r1_rdata;

  modport master (
    output r0_valid, r0_we, r0_addr, r0_wdata,
    output r1_valid, r1_we, r1_addr, r1_wdata,
    input  r0_ready, r0_rvalid, r0_rdata,
    input  r1_ready, r1_rvalid, r1_rdata
  );

  modport slave (
    input  r0_valid, r0_we, r0_addr, r0_wdata,
    input  r1_valid, r1_we, r1_addr, r1_wdata,
    output r0_ready, r0_rvalid, r0_rdata,
    output r1_ready, r1_rvalid, r1_rdata
  );

endinterface

// File: rtl/bram1.sv
// Simple dual-port block RAM: one write port, one 1-cycle registered read port, read-before-write.
module bram1 #(
  parameter int ABITS = 8,
  parameter int DBITS = 8
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [ABITS-1:0] i_wr_addr,
  input  logic [DBITS-1:0] i_wr_data,
  input  logic [ABITS-1:0] i_rd_addr,
  output logic [DBITS-1:0] o_rd_data
);

  logic [DBITS-1:0] r_mem [2**ABITS];
  logic [DBITS-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/bram1_rr2.sv
// Two-way round-robin grant: on contention the priority holder wins, and priority then moves to the other requester.
module bram1_rr2
  import bram1_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  req_idx_t   r_prio;
  logic [1:0] w_gnt;

  always_comb begin
    w_gnt = 2'b00;
    if (i_en) begin
      if (i_req == 2'b11) w_gnt = prio_onehot(r_prio);
      else                w_gnt = i_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= REQ0;
    end else if (w_gnt[0]) begin
      r_prio <= REQ1;
    end else if (w_gnt[1]) begin
      r_prio <= REQ0;
    end
  end

  assign o_gnt = w_gnt;

endmodule

// File: rtl/bram1_port_arb.sv
// Arbitrates two requesters onto one BRAM (independent write/read round-robin) after an optional clear sweep.
module bram1_port_arb
  import bram1_arb_pkg::*;
#(
  parameter int               ABITS    = 8,
  parameter int               DBITS    = 8,
  parameter int               TRANSP   = 0,
  parameter int               INIT_EN  = 1,
  parameter logic [DBITS-1:0] INIT_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  bram1_port_arb_if.slave     bus,
  output logic                mem_wr_en,
  output logic [ABITS-1:0]    mem_wr_addr,
  output logic [DBITS-1:0]    mem_wr_data,
  output logic [ABITS-1:0]    mem_rd_addr,
  input  logic [DBITS-1:0]    mem_rd_data,
  output logic                init_done
);

  arb_state_t       r_state;
  logic [ABITS-1:0] r_cnt;
  logic             r_init_done;
  logic [1:0]       r_rvalid;
  logic [ABITS-1:0] r_rd_addr;
  logic             r_coll;
  logic [DBITS-1:0] r_wdata_q;
  logic [DBITS-1:0] r_rdata0;
  logic [DBITS-1:0] r_rdata1;

  logic             w_run;
  logic [1:0]       w_wr_req;
  logic [1:0]       w_rd_req;
  logic [1:0]       w_wr_gnt;
  logic [1:0]       w_rd_gnt;
  logic             w_wr_any;
  logic             w_rd_any;
  logic [ABITS-1:0] w_wr_addr;
  logic [DBITS-1:0] w_wr_data;
  logic [ABITS-1:0] w_rd_addr;
  logic [1:0]       w_rv;
  logic [DBITS-1:0] w_fresh;

  assign w_run    = (r_state == ST_RUN) && !rst;
  assign w_wr_req = {bus.r1_valid &  bus.r1_we, bus.r0_valid &  bus.r0_we};
  assign w_rd_req = {bus.r1_valid & ~bus.r1_we, bus.r0_valid & ~bus.r0_we};

  bram1_rr2 u_wr_rr (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_run),
    .i_req (w_wr_req),
    .o_gnt (w_wr_gnt)
  );

  bram1_rr2 u_rd_rr (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_run),
    .i_req (w_rd_req),
    .o_gnt (w_rd_gnt)
  );

  assign w_wr_any  = |w_wr_gnt;
  assign w_rd_any  = |w_rd_gnt;
  assign w_wr_addr = w_wr_gnt[1] ? bus.r1_addr  : bus.r0_addr;
  assign w_wr_data = w_wr_gnt[1] ? bus.r1_wdata : bus.r0_wdata;
  assign w_rd_addr = w_rd_gnt[1] ? bus.r1_addr  : bus.r0_addr;

  assign bus.r0_ready = w_wr_gnt[0] | w_rd_gnt[0];
  assign bus.r1_ready = w_wr_gnt[1] | w_rd_gnt[1];

  always_comb begin
    mem_wr_en   = 1'b0;
    mem_wr_addr = w_wr_addr;
    mem_wr_data = w_wr_data;
    if (!rst && r_state == ST_INIT) begin
      mem_wr_en   = 1'b1;
      mem_wr_addr = r_cnt;
      mem_wr_data = INIT_VAL;
    end else if (w_wr_any) begin
      mem_wr_en   = 1'b1;
    end
  end

  assign mem_rd_addr = rst ? '0 : (w_rd_any ? w_rd_addr : r_rd_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (&r_cnt) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end
        end
        ST_RUN: r_init_done <= 1'b1;
        default: r_state <= ST_INIT;
      endcase
    end
  end

  // The memory read is non-transparent, so a same-address write in the read cycle is remembered for TRANSP=1.
  assign w_rv    = r_rvalid & {2{~rst}};
  assign w_fresh = ((TRANSP != 0) && r_coll) ? r_wdata_q : mem_rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid  <= 2'b00;
      r_rd_addr <= '0;
      r_coll    <= 1'b0;
      r_wdata_q <= '0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid  <= w_rd_gnt;
      r_coll    <= w_rd_any && w_wr_any && (w_rd_addr == w_wr_addr);
      r_wdata_q <= w_wr_data;
      if (w_rd_any) r_rd_addr <= w_rd_addr;
      if (w_rv[0])  r_rdata0  <= w_fresh;
      if (w_rv[1])  r_rdata1  <= w_fresh;
    end
  end

  assign bus.r0_rvalid = w_rv[0];
  assign bus.r1_rvalid = w_rv[1];
  assign bus.r0_rdata  = w_rv[0] ? w_fresh : r_rdata0;
  assign bus.r1_rdata  = w_rv[1] ? w_fresh : r_rdata1;
  assign init_done     = r_init_done;

endmodule

// File: tb/tb_bram1_port_arb.sv
// Directed bench: arbiter paired with bram1 (8x256), checks reset, clear sweep, arbitration and read responses.
module tb_bram1_port_arb;

  localparam int TRANSP = 0;

  logic       clk;
  logic       rst;
  logic       memWrEn;
  logic [7:0] memWrAddr;
  logic [7:0] memWrData;
  logic [7:0] memRdAddr;
  logic [7:0] memRdData;
  logic       initDone;

  int total;
  int bad;
  int waitCycles;

  bram1_port_arb_if #(.ABITS(8), .DBITS(8)) bus ();

  bram1_port_arb #(
    .ABITS(8), .DBITS(8), .TRANSP(TRANSP), .INIT_EN(1), .INIT_VAL(8'h00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .mem_wr_en   (memWrEn),
    .mem_wr_addr (memWrAddr),
    .mem_wr_data (memWrData),
    .mem_rd_addr (memRdAddr),
    .mem_rd_data (memRdData),
    .init_done   (initDone)
  );

  bram1 #(.ABITS(8), .DBITS(8)) mem (
    .clk       (clk),
    .i_wr_en   (memWrEn),
    .i_wr_addr (memWrAddr),
    .i_wr_data (memWrData),
    .i_rd_addr (memRdAddr),
    .o_rd_data (memRdData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic we0, input logic [7:0] a0, input logic [7:0] d0,
                               input logic v1, input logic we1, input logic [7:0] a1, input logic [7:0] d1);
    bus.r0_valid = v0; bus.r0_we = we0; bus.r0_addr = a0; bus.r0_wdata = d0;
    bus.r1_valid = v1; bus.r1_we = we1; bus.r1_addr = a1; bus.r1_wdata = d1;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // Waits for the clear sweep to finish; the cycle count from the current point is returned.
  task automatic waitInit(output int n);
    n = 0;
    while (!initDone && n < 400) begin
      tick();
      n++;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h12, 8'h00, 1'b1, 1'b1, 8'h34, 8'h56);
    repeat (3) tick();
    checkOutput("rst_ready", {30'd0, bus.r1_ready, bus.r0_ready}, 32'h0);
    checkOutput("rst_rvalid", {30'd0, bus.r1_rvalid, bus.r0_rvalid}, 32'h0);
    checkOutput("rst_wr_en", {31'd0, memWrEn}, 32'h0);
    checkOutput("rst_init_done", {31'd0, initDone}, 32'h0);
    checkOutput("rst_rdata0", {24'd0, bus.r0_rdata}, 32'h0);
    checkOutput("rst_rd_addr", {24'd0, memRdAddr}, 32'h0);

    // Sweep starts at address 0 with requesters held off; interrupt it at 0x80.
    rst = 1'b0;
    #1;
    checkOutput("init_wr_en", {31'd0, memWrEn}, 32'h1);
    checkOutput("init_wr_addr", {24'd0, memWrAddr}, 32'h0);
    checkOutput("init_ready", {30'd0, bus.r1_ready, bus.r0_ready}, 32'h0);
    idle();
    repeat (128) tick();
    checkOutput("init_addr_80", {24'd0, memWrAddr}, 32'h80);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checkOutput("restart_addr", {24'd0, memWrAddr}, 32'h00);
    checkOutput("restart_done", {31'd0, initDone}, 32'h0);
    waitInit(waitCycles);
    checkOutput("init_cycles", waitCycles, 32'd256);

    // Single read of a cleared location.
    applyStimulus(1'b1, 1'b0, 8'h4A, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("rd4a_ready", {31'd0, bus.r0_ready}, 32'h1);
    checkOutput("rd4a_addr", {24'd0, memRdAddr}, 32'h4A);
    checkOutput("rd4a_no_wr", {31'd0, memWrEn}, 32'h0);
    tick();
    idle();
    checkOutput("rd4a_rvalid", {31'd0, bus.r0_rvalid}, 32'h1);
    checkOutput("rd4a_rdata", {24'd0, bus.r0_rdata}, 32'h00);
    checkOutput("rd_addr_hold", {24'd0, memRdAddr}, 32'h4A);
    tick();
    checkOutput("rd4a_rvalid_drop", {31'd0, bus.r0_rvalid}, 32'h0);

    // Two writers to 0x10: r0 wins first, then r1 (its data survives).
    applyStimulus(1'b1, 1'b1, 8'h10, 8'hAA, 1'b1, 1'b1, 8'h10, 8'h55);
    checkOutput("ww1_ready", {30'd0, bus.r1_ready, bus.r0_ready}, 32'h1);
    checkOutput("ww1_data", {24'd0, memWrData}, 32'hAA);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h10, 8'h55);
    checkOutput("ww2_ready", {30'd0, bus.r1_ready, bus.r0_ready}, 32'h2);
    checkOutput("ww2_data", {24'd0, memWrData}, 32'h55);
    tick();
    applyStimulus(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    idle();
    checkOutput("rd10_rdata", {24'd0, bus.r0_rdata}, 32'h55);
    tick();

    // Collision at 0x20: prior value 0x11, r0 writes 0x33 while r1 reads.
    applyStimulus(1'b1, 1'b1, 8'h20, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    applyStimulus(1'b1, 1'b1, 8'h20, 8'h33, 1'b1, 1'b0, 8'h20, 8'h00);
    checkOutput("coll_ready", {30'd0, bus.r1_ready, bus.r0_ready}, 32'h3);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
    checkOutput("coll_rvalid1", {31'd0, bus.r1_rvalid}, 32'h1);
    checkOutput("coll_rdata1", {24'd0, bus.r1_rdata}, (TRANSP != 0) ? 32'h33 : 32'h11);
    tick();
    // A write in the cycle after a read must not leak into that read's response.
    applyStimulus(1'b1, 1'b1, 8'h20, 8'h77, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("rdw_rdata1", {24'd0, bus.r1_rdata}, 32'h33);
    tick();
    applyStimulus(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    idle();
    checkOutput("rd20_rdata0", {24'd0, bus.r0_rdata}, 32'h77);
    tick();

    // Read priority now rests with r1 (last read grant went to r0); both read for 8 cycles.
    begin
      logic [1:0] expGnt;
      logic [1:0] prevGnt;
      prevGnt = 2'b00;
      applyStimulus(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
      for (int k = 0; k < 8; k++) begin
        expGnt = (k % 2 == 0) ? 2'b10 : 2'b01;
        checkOutput($sformatf("rr_gnt%0d", k), {30'd0, bus.r1_ready, bus.r0_ready}, {30'd0, expGnt});
        checkOutput($sformatf("rr_rv%0d", k), {30'd0, bus.r1_rvalid, bus.r0_rvalid}, {30'd0, prevGnt});
        if (prevGnt == 2'b01) checkOutput($sformatf("rr_d0_%0d", k), {24'd0, bus.r0_rdata}, 32'h55);
        if (prevGnt == 2'b10) checkOutput($sformatf("rr_d1_%0d", k), {24'd0, bus.r1_rdata}, 32'h77);
        prevGnt = expGnt;
        tick();
        #1;
      end
      idle();
      checkOutput("rr_rv_last", {30'd0, bus.r1_rvalid, bus.r0_rvalid}, {30'd0, prevGnt});
      tick();
      checkOutput("rr_rv_none", {30'd0, bus.r1_rvalid, bus.r0_rvalid}, 32'h0);
    end

    // Reset in the cycle after a read handshake drops the response.
    applyStimulus(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("rstrd_ready", {31'd0, bus.r0_ready}, 32'h1);
    tick();
    rst = 1'b1;
    idle();
    checkOutput("rstrd_rvalid_a", {31'd0, bus.r0_rvalid}, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rstrd_rvalid_b", {31'd0, bus.r0_rvalid}, 32'h0);
    checkOutput("rstrd_done", {31'd0, initDone}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
